// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types for the fetch/LSU memory arbiter.
//   arb_state_e : transaction FSM state (IDLE, REQ, RESP)
//   arb_owner_e : which requester owns the current transaction
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_IF  = 1'b0,
        OWNER_LSU = 1'b1
    } arb_owner_e;

    localparam logic [3:0] FetchBe = 4'hF;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (IF) and the
// load/store unit (LSU). At most one transaction is outstanding; ties are
// broken round-robin.
// Ports:
//   clk, reset                    : clock, async active-high reset
//   if_req/if_addr/if_kill        : fetch request and pipeline flush
//   if_gnt/if_rvalid/if_rdata/if_err : fetch accept and response
//   lsu_req/we/be/addr/wdata      : data request
//   lsu_gnt/rvalid/rdata/err      : data accept and response
//   mem_req/we/be/addr/wdata      : shared memory request
//   mem_gnt/rvalid/rdata/err      : memory accept and response
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_kill,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [3:0]  lsu_be,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_gnt,
    output logic        lsu_rvalid,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err
);

    arb_state_e r_state, w_state_next;
    arb_owner_e r_owner, r_last_owner, w_pick, w_owner;
    logic       r_drop, w_drop_next;
    logic       w_any_req, w_grant, w_kill, w_resp_done, w_deliver;

    // Arbitration: lone requester wins; on a tie the one not granted last wins.
    always_comb begin
        w_any_req = if_req | lsu_req;
        if (if_req && !lsu_req) begin
            w_pick = OWNER_IF;
        end else if (!if_req && lsu_req) begin
            w_pick = OWNER_LSU;
        end else begin
            w_pick = (r_last_owner == OWNER_LSU) ? OWNER_IF : OWNER_LSU;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_owner      = r_owner;
        mem_req      = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_owner = w_pick;
                if (w_any_req && !reset) begin
                    mem_req      = 1'b1;
                    w_state_next = mem_gnt ? RESP : REQ;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Request fields follow the effective owner; idle bus drives zeros.
    always_comb begin
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (mem_req) begin
            if (w_owner == OWNER_LSU) begin
                mem_we    = lsu_we;
                mem_be    = lsu_be;
                mem_addr  = lsu_addr;
                mem_wdata = lsu_wdata;
            end else begin
                mem_be    = FetchBe;
                mem_addr  = if_addr;
            end
        end
    end

    always_comb begin
        w_grant     = mem_req & mem_gnt;
        if_gnt      = w_grant & (w_owner == OWNER_IF);
        lsu_gnt     = w_grant & (w_owner == OWNER_LSU);
        // A flush only matters once IF actually owns the transaction.
        w_kill      = if_kill & (w_owner == OWNER_IF) &
                      ((r_state == REQ) || (r_state == RESP) || (r_state == IDLE && w_grant));
        w_resp_done = (r_state == RESP) & mem_rvalid;
        w_deliver   = w_resp_done & ~((w_owner == OWNER_IF) & (r_drop | w_kill));
        if_rvalid   = w_deliver & (w_owner == OWNER_IF);
        lsu_rvalid  = w_deliver & (w_owner == OWNER_LSU);
        if_err      = if_rvalid & mem_err;
        lsu_err     = lsu_rvalid & mem_err;
        if_rdata    = mem_rdata;
        lsu_rdata   = mem_rdata;
        if (w_resp_done) begin
            w_drop_next = 1'b0;
        end else if (w_kill) begin
            w_drop_next = 1'b1;
        end else begin
            w_drop_next = r_drop;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_owner      <= OWNER_LSU;
            r_last_owner <= OWNER_LSU;
            r_drop       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_drop  <= w_drop_next;
            if (r_state == IDLE && w_any_req) begin
                r_owner <= w_pick;
            end
            if (w_grant) begin
                r_last_owner <= w_owner;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk, reset;
    logic        if_req, if_kill, if_gnt, if_rvalid, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        lsu_req, lsu_we, lsu_gnt, lsu_rvalid, lsu_err;
    logic [3:0]  lsu_be;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid, mem_err;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        is_if;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];

    mem_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_kill    (if_kill),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .if_err     (if_err),
        .lsu_req    (lsu_req),
        .lsu_we     (lsu_we),
        .lsu_be     (lsu_be),
        .lsu_addr   (lsu_addr),
        .lsu_wdata  (lsu_wdata),
        .lsu_gnt    (lsu_gnt),
        .lsu_rvalid (lsu_rvalid),
        .lsu_rdata  (lsu_rdata),
        .lsu_err    (lsu_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_err    (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: responses are pushed in the cycle the bench drives
    // mem_rvalid and must appear on the owner's port in that same cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [36:0] got, want;
        if (!reset && (sb.size() != 0 || if_rvalid || lsu_rvalid)) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: if_rvalid=%0b lsu_rvalid=%0b, required no response",
                         if_rvalid, lsu_rvalid);
            end else begin
                e    = sb.pop_front();
                got  = {if_rvalid, lsu_rvalid, (e.is_if ? if_rdata : lsu_rdata), if_err, lsu_err};
                want = {e.is_if, ~e.is_if, e.data, e.is_if & e.err, ~e.is_if & e.err};
                if (got !== want) begin
                    bad++;
                    $display("FAIL sb_response: got {ifv,lsuv,data,iferr,lsuerr}=%h required %h",
                             got, want);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req = 0; if_addr = 0; if_kill = 0;
        lsu_req = 0; lsu_we = 0; lsu_be = 0; lsu_addr = 0; lsu_wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; mem_err = 0;
    endtask

    task automatic push_exp(input logic is_if, input logic [31:0] d, input logic err);
        exp_t e;
        e.is_if = is_if; e.data = d; e.err = err;
        sb.push_back(e);
    endtask

    task automatic pulse_reset();
        step(); reset = 1;
        step(); reset = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        if_req = 1; lsu_req = 1; mem_gnt = 1; mem_rvalid = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (mem_req !== 1'b0) begin
            bad++; $display("FAIL reset_mem_req: got %0b required 0", mem_req);
        end
        total++;
        if ({if_gnt, lsu_gnt} !== 2'b00) begin
            bad++; $display("FAIL reset_gnt: got %b required 00", {if_gnt, lsu_gnt});
        end
        total++;
        if ({if_rvalid, lsu_rvalid, if_err, lsu_err} !== 4'b0000) begin
            bad++; $display("FAIL reset_resp: got %b required 0000",
                            {if_rvalid, lsu_rvalid, if_err, lsu_err});
        end
        step(); clear_inputs(); reset = 0;
    endtask

    task automatic test_single_fetch();
        step();
        if_req = 1; if_addr = 32'h100; mem_gnt = 1;
        lsu_we = 1; lsu_be = 4'h5; lsu_wdata = 32'hdeadbeef;
        @(negedge clk);
        total++;
        if ({mem_req, mem_addr, mem_we, mem_be, mem_wdata} !== {1'b1, 32'h100, 1'b0, 4'hF, 32'h0}) begin
            bad++; $display("FAIL fetch_fields: got req=%0b addr=%h we=%0b be=%h wdata=%h required 1 100 0 f 0",
                            mem_req, mem_addr, mem_we, mem_be, mem_wdata);
        end
        total++;
        if ({if_gnt, lsu_gnt} !== 2'b10) begin
            bad++; $display("FAIL fetch_gnt: got %b required 10", {if_gnt, lsu_gnt});
        end
        step();
        if_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h13;
        push_exp(1'b1, 32'h13, 1'b0);
        @(negedge clk);
        total++;
        if (mem_req !== 1'b0) begin
            bad++; $display("FAIL fetch_resp_req: got %0b required 0", mem_req);
        end
        step(); clear_inputs();
    endtask

    task automatic test_round_robin();
        logic exp_if;
        pulse_reset();
        step();
        if_req = 1; if_addr = 32'h400;
        lsu_req = 1; lsu_we = 1; lsu_be = 4'hF; lsu_addr = 32'h3000; lsu_wdata = 32'h12345678;
        for (int i = 0; i < 4; i++) begin
            exp_if = (i % 2 == 0);
            if (i > 0) step();
            mem_gnt = 1; mem_rvalid = 0;
            @(negedge clk);
            total++;
            if ({if_gnt, lsu_gnt, mem_addr} !== {exp_if, ~exp_if, (exp_if ? 32'h400 : 32'h3000)}) begin
                bad++; $display("FAIL rr_grant[%0d]: got ifg=%0b lsug=%0b addr=%h required if_owner=%0b",
                                i, if_gnt, lsu_gnt, mem_addr, exp_if);
            end
            step();
            mem_rvalid = 1; mem_rdata = 32'h50 + 32'(i);
            push_exp(exp_if, 32'h50 + 32'(i), 1'b0);
            @(negedge clk);
            total++;
            if ({mem_req, if_gnt, lsu_gnt} !== 3'b000) begin
                bad++; $display("FAIL rr_resp_idle[%0d]: got %b required 000",
                                i, {mem_req, if_gnt, lsu_gnt});
            end
        end
        step(); clear_inputs();
    endtask

    task automatic test_held_lsu();
        step();
        lsu_req = 1; lsu_we = 1; lsu_be = 4'h3; lsu_addr = 32'h2000; lsu_wdata = 32'ha5a50f0f;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) step();
            if (c == 1) begin if_req = 1; if_addr = 32'h500; end
            if (c == 3) mem_gnt = 1;
            @(negedge clk);
            total++;
            if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !==
                {1'b1, 1'b1, 4'h3, 32'h2000, 32'ha5a50f0f}) begin
                bad++; $display("FAIL held_fields[%0d]: got req=%0b we=%0b be=%h addr=%h wdata=%h required LSU store",
                                c, mem_req, mem_we, mem_be, mem_addr, mem_wdata);
            end
            total++;
            if ({if_gnt, lsu_gnt} !== ((c == 3) ? 2'b01 : 2'b00)) begin
                bad++; $display("FAIL held_gnt[%0d]: got %b required %b", c, {if_gnt, lsu_gnt},
                                ((c == 3) ? 2'b01 : 2'b00));
            end
        end
        step();
        lsu_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0;
        push_exp(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        total++;
        if ({mem_req, if_gnt} !== 2'b00) begin
            bad++; $display("FAIL held_resp: got req/ifg=%b required 00", {mem_req, if_gnt});
        end
        step();
        mem_rvalid = 0; mem_gnt = 1;
        @(negedge clk);
        total++;
        if ({if_gnt, mem_addr} !== {1'b1, 32'h500}) begin
            bad++; $display("FAIL held_if_after: got ifg=%0b addr=%h required 1 500", if_gnt, mem_addr);
        end
        step();
        if_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h600d;
        push_exp(1'b1, 32'h600d, 1'b0);
        step(); clear_inputs();
    endtask

    task automatic test_kill();
        step();
        if_req = 1; if_addr = 32'h700; mem_gnt = 1;
        @(negedge clk);
        total++;
        if (if_gnt !== 1'b1) begin
            bad++; $display("FAIL kill_gnt: got %0b required 1", if_gnt);
        end
        step(); if_req = 0; mem_gnt = 0; if_kill = 1;
        step(); if_kill = 0;
        step(); mem_rvalid = 1; mem_rdata = 32'hbad;
        @(negedge clk);
        total++;
        if (if_rvalid !== 1'b0) begin
            bad++; $display("FAIL kill_dropped: got if_rvalid=%0b required 0", if_rvalid);
        end
        step();
        mem_rvalid = 0; if_req = 1; if_addr = 32'h704; mem_gnt = 1;
        @(negedge clk);
        total++;
        if (if_gnt !== 1'b1) begin
            bad++; $display("FAIL kill_idle_after: got if_gnt=%0b required 1", if_gnt);
        end
        step();
        if_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h77;
        push_exp(1'b1, 32'h77, 1'b0);
        step(); clear_inputs();
    endtask

    task automatic test_load_err();
        step();
        lsu_req = 1; lsu_we = 0; lsu_be = 4'hF; lsu_addr = 32'h44; mem_gnt = 1;
        @(negedge clk);
        total++;
        if ({lsu_gnt, mem_we} !== 2'b10) begin
            bad++; $display("FAIL err_gnt: got lsu_gnt/we=%b required 10", {lsu_gnt, mem_we});
        end
        // if_kill during an LSU transaction must not affect it.
        step();
        lsu_req = 0; mem_gnt = 0; if_kill = 1; mem_rvalid = 1; mem_err = 1; mem_rdata = 32'he;
        push_exp(1'b0, 32'he, 1'b1);
        step(); clear_inputs();
    endtask

    task automatic test_reset_in_resp();
        step();
        if_req = 1; if_addr = 32'h800; mem_gnt = 1;
        step();
        if_req = 0; mem_gnt = 0; reset = 1;
        @(negedge clk);
        total++;
        if ({mem_req, if_rvalid, lsu_rvalid} !== 3'b000) begin
            bad++; $display("FAIL rst_resp_outputs: got %b required 000", {mem_req, if_rvalid, lsu_rvalid});
        end
        step();
        reset = 0; mem_rvalid = 1; mem_rdata = 32'h99;
        @(negedge clk);
        total++;
        if ({if_rvalid, lsu_rvalid, mem_req} !== 3'b000) begin
            bad++; $display("FAIL rst_stale_rvalid: got %b required 000", {if_rvalid, lsu_rvalid, mem_req});
        end
        step();
        mem_rvalid = 0; if_req = 1; if_addr = 32'h880; lsu_req = 1; lsu_addr = 32'h900; mem_gnt = 1;
        @(negedge clk);
        total++;
        if ({if_gnt, lsu_gnt, mem_addr} !== {2'b10, 32'h880}) begin
            bad++; $display("FAIL rst_tie_if: got gnt=%b addr=%h required 10 880", {if_gnt, lsu_gnt}, mem_addr);
        end
        step();
        if_req = 0; lsu_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h31;
        push_exp(1'b1, 32'h31, 1'b0);
        step(); clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        test_reset();
        test_single_fetch();
        test_round_robin();
        test_held_lsu();
        test_kill();
        test_load_err();
        test_reset_in_resp();
        @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL sb_leftover: got %0d pending required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter
Interface
REQ-001 clk  in  1  core clock; all state on rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 if_req  in  1  fetch request; held with if_addr until if_gnt.
REQ-004 if_addr  in  32  fetch word address.
REQ-005 if_kill  in  1  pipeline flush; discard the in-flight fetch response.
REQ-006 if_gnt  out  1  fetch request accepted.
REQ-007 if_rvalid  out  1  fetch response valid, one cycle.
REQ-008 if_rdata  out  32  fetch data.
REQ-009 if_err  out  1  fetch bus error, qualified by if_rvalid.
REQ-010 lsu_req  in  1  data request; held with attributes until lsu_gnt.
REQ-011 lsu_we  in  1  1=store, 0=load.
REQ-012 lsu_be  in  4  byte enables.
REQ-013 lsu_addr  in  32  data address.
REQ-014 lsu_wdata  in  32  store data.
REQ-015 lsu_gnt  out  1  data request accepted.
REQ-016 lsu_rvalid  out  1  data response valid, one cycle.
REQ-017 lsu_rdata  out  32  load data.
REQ-018 lsu_err  out  1  data bus error, qualified by lsu_rvalid.
REQ-019 mem_req  out  1  shared memory request.
REQ-020 mem_we  out  1  write strobe; 0 for fetches.
REQ-021 mem_be  out  4  byte enables; 4'hF for fetches.
REQ-022 mem_addr  out  32  address.
REQ-023 mem_wdata  out  32  write data; 0 for fetches.
REQ-024 mem_gnt  in  1  memory accepted request.
REQ-025 mem_rvalid  in  1  memory response valid.
REQ-026 mem_rdata  in  32  response data.
REQ-027 mem_err  in  1  response error.
Function
REQ-028 FSM states IDLE, REQ, RESP; at most one transaction outstanding.
REQ-029 IDLE: if any request, pick owner, drive mem_req=1 combinationally with owner's fields; mem_gnt same cycle -> RESP, else -> REQ with owner latched.
REQ-030 Arbitration: single requester wins; both requesting -> round-robin, the requester not granted last wins; last_owner updates on mem_gnt.
REQ-031 REQ: mem_req=1 with latched owner's fields, no re-arbitration, ignoring requester deassertion; mem_gnt -> RESP.
REQ-032 if_gnt = mem_gnt & owner==IF & state in {IDLE,REQ}; lsu_gnt likewise for LSU.
REQ-033 RESP: mem_req=0; on mem_rvalid route rdata/err to owner's rvalid/rdata/err for that cycle, -> IDLE; new arbitration earliest next cycle.
REQ-034 Minimum latency: request cycle N with mem_gnt, mem_rvalid N+1 -> requester rvalid N+1, next grant N+2.
REQ-035 if_kill with IF owner in REQ or RESP (or same cycle as IDLE grant) sets drop flag; matching response consumed, if_rvalid held 0; flag clears on that mem_rvalid.
REQ-036 if_kill without IF owner, and all kills for LSU transactions, are ignored.
REQ-037 Non-owner rvalid/err always 0; rdata outputs pass mem_rdata unqualified.
REQ-038 mem_rvalid outside RESP is ignored; mem_gnt outside IDLE/REQ is ignored.
Reset
REQ-039 On reset: state=IDLE, last_owner=LSU (IF wins first tie), drop=0, all gnt/rvalid/err and mem_req=0; reset mid-transaction abandons it without response.
Structure
REQ-040 Package holds arb_state_e (IDLE/REQ/RESP) and arb_owner_e (OWNER_IF/OWNER_LSU); no sub-module, arbiter inline.
Verification
REQ-041 if_req addr 0x100, mem_gnt same cycle, mem_rvalid next with rdata 0x13 -> if_gnt cycle 0, if_rvalid/if_rdata=0x13 cycle 1, lsu outputs 0.
REQ-042 if_req and lsu_req both after reset -> IF first; both held -> LSU next, then IF alternating.
REQ-043 lsu store addr 0x2000 be 4'h3, mem_gnt delayed 3 cycles while if_req rises -> mem fields stay LSU, lsu_gnt on cycle 3, if_gnt 0 until LSU response.
REQ-044 Fetch granted, if_kill in RESP, mem_rvalid 2 cycles later -> if_rvalid stays 0, IDLE after, next fetch response delivered.
REQ-045 Load with mem_err=1 on response -> lsu_rvalid=1, lsu_err=1, if_err=0.
REQ-046 reset asserted in RESP, then mem_rvalid -> no rvalid output, state IDLE, next tie goes to IF.
